program_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a framed byte

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader_byte_packer.sv | 51 +++++
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared widths and loader state encoding for the processor slice.
package processor_pkg;

    localparam int INSTR_W   = 16;
    localparam int IM_ADDR_W = 7;
    localparam int BYTE_W    = 8;

    typedef enum logic [3:0] {
        LD_IDLE  = 4'd0,
        LD_COUNT = 4'd1,
        LD_HI    = 4'd2,
        LD_LO    = 4'd3,
        LD_WRITE = 4'd4,
        LD_CHECK = 4'd5,
        LD_DONE  = 4'd6,
        LD_ERR   = 4'd7
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave = loader side, master = host / memory side.
interface program_loader_if
    import processor_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = INSTR_W
);
    logic              In_Valid;
    logic [BYTE_W-1:0] In_Data;
    logic              In_Ready;
    logic              IM_Wr;
    logic [ADDR_W-1:0] IM_Addr;
    logic [DATA_W-1:0] IM_Data;

    modport master (
        output In_Valid, In_Data,
        input  In_Ready, IM_Wr, IM_Addr, IM_Data
    );

    modport slave (
        input  In_Valid, In_Data,
        output In_Ready, IM_Wr, IM_Addr, IM_Data
    );
endinterface

// File: rtl/program_loader_byte_packer.sv
// High/low byte latches and the running XOR of the frame.
module byte_packer
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              clr,
    input  logic              acc,
    input  logic              ld_hi,
    input  logic              ld_lo,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] hi,
    output logic [BYTE_W-1:0] lo,
    output logic [BYTE_W-1:0] chk
);
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic [BYTE_W-1:0] xor_q, xor_d;

    // Next-state for the byte latches and the checksum accumulator.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        xor_d = xor_q;
        if (clr) begin
            xor_d = '0;
        end else if (acc) begin
            xor_d = xor_q ^ din;
        end
        if (ld_hi) hi_d = din;
        if (ld_lo) lo_d = din;
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            xor_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            xor_q <= xor_d;
        end
    end

    assign hi  = hi_q;
    assign lo  = lo_q;
    assign chk = xor_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: frames a host byte stream into 16-bit instruction writes
// and keeps the processor in reset until a load passes its checksum.
//
//   state | meaning
//   IDLE  | after reset, processor held, waiting for Start
//   COUNT | waiting for the word-count byte N
//   HI    | waiting for the high byte of the next word
//   LO    | waiting for the low byte of the next word
//   WRITE | one-cycle memory write of {hi,lo}, no byte accepted
//   CHECK | waiting for the checksum byte
//   DONE  | checksum matched, processor released
//   ERR   | checksum mismatch, processor held
module program_loader
    import processor_pkg::*;
#(
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int DATA_W    = INSTR_W,
    parameter int BASE_ADDR = 0
)(
    input  logic                clk,
    input  logic                Reset,
    input  logic                Start,
    program_loader_if.slave     bus,
    output logic                Hold,
    output logic                Done,
    output logic                Error,
    output logic [3:0]          State
);
    localparam logic [3:0] ST_IDLE  = LD_IDLE;
    localparam logic [3:0] ST_COUNT = LD_COUNT;
    localparam logic [3:0] ST_HI    = LD_HI;
    localparam logic [3:0] ST_LO    = LD_LO;
    localparam logic [3:0] ST_WRITE = LD_WRITE;
    localparam logic [3:0] ST_CHECK = LD_CHECK;
    localparam logic [3:0] ST_DONE  = LD_DONE;
    localparam logic [3:0] ST_ERR   = LD_ERR;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [3:0]        state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              in_ready;
    logic              accept;
    logic              pk_clr, pk_acc, pk_ld_hi, pk_ld_lo;
    logic [BYTE_W-1:0] pk_hi, pk_lo, pk_chk;

    assign in_ready = (state_q == ST_COUNT) || (state_q == ST_HI) ||
                      (state_q == ST_LO)    || (state_q == ST_CHECK);
    assign accept   = bus.In_Valid && in_ready;

    byte_packer u_packer (
        .clk   (clk),
        .Reset (Reset),
        .clr   (pk_clr),
        .acc   (pk_acc),
        .ld_hi (pk_ld_hi),
        .ld_lo (pk_ld_lo),
        .din   (bus.In_Data),
        .hi    (pk_hi),
        .lo    (pk_lo),
        .chk   (pk_chk)
    );

    // Frame sequencing, word counter and write-address generation.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pk_clr   = 1'b0;
        pk_acc   = 1'b0;
        pk_ld_hi = 1'b0;
        pk_ld_lo = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    state_d = ST_COUNT;
                    idx_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    n_d     = bus.In_Data;
                    pk_acc  = 1'b1;
                    state_d = (bus.In_Data == 8'd0) ? ST_CHECK : ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
                    pk_acc   = 1'b1;
                    pk_ld_hi = 1'b1;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    pk_acc   = 1'b1;
                    pk_ld_lo = 1'b1;
                    addr_d   = BASE + ADDR_W'(idx_q);
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Capture the word so IM_Data keeps it after the strobe.
                data_d  = DATA_W'({pk_hi, pk_lo});
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == n_q - 8'd1) ? ST_CHECK : ST_HI;
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (bus.In_Data == pk_chk) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.In_Ready = in_ready;
    assign bus.IM_Wr    = (state_q == ST_WRITE);
    assign bus.IM_Addr  = addr_q;
    // The latched word is live during WRITE; afterwards the captured copy holds.
    assign bus.IM_Data  = (state_q == ST_WRITE) ? DATA_W'({pk_hi, pk_lo}) : data_q;

    assign Hold  = (state_q != ST_DONE);
    assign Done  = (state_q == ST_DONE);
    assign Error = (state_q == ST_ERR);
    assign State = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one instance at base 0, one at base 7F.
module tb_program_loader;
    import processor_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic Reset;
    logic start0, start1;
    logic hold0, done0, err0, hold1, done1, err1;
    logic [3:0] state0, state1;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_bad0 = 0;
    int rdy_bad1 = 0;
    logic [31:0] wr0[$];
    logic [31:0] wr1[$];

    program_loader_if #(.ADDR_W(7), .DATA_W(16)) bus0 ();
    program_loader_if #(.ADDR_W(7), .DATA_W(16)) bus1 ();

    program_loader #(.ADDR_W(7), .DATA_W(16), .BASE_ADDR(0)) u_dut (
        .clk   (clk),
        .Reset (Reset),
        .Start (start0),
        .bus   (bus0),
        .Hold  (hold0),
        .Done  (done0),
        .Error (err0),
        .State (state0)
    );

    program_loader #(.ADDR_W(7), .DATA_W(16), .BASE_ADDR(127)) u_wrap (
        .clk   (clk),
        .Reset (Reset),
        .Start (start1),
        .bus   (bus1),
        .Hold  (hold1),
        .Done  (done1),
        .Error (err1),
        .State (state1)
    );

    always #5 clk = ~clk;

    // Log every write strobe and flag any In_Ready seen alongside it.
    always @(negedge clk) begin
        if (bus0.IM_Wr) begin
            wr0.push_back({9'd0, bus0.IM_Addr, bus0.IM_Data});
            if (bus0.In_Ready) rdy_bad0++;
        end
        if (bus1.IM_Wr) begin
            wr1.push_back({9'd0, bus1.IM_Addr, bus1.IM_Data});
            if (bus1.In_Ready) rdy_bad1++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.In_Ready : bus1.In_Ready;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin
            bus0.In_Valid = v;
            bus0.In_Data  = b;
        end else begin
            bus1.In_Valid = v;
            bus1.In_Data  = b;
        end
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input int bubbles);
        int wait_cyc;
        set_in(sel, 1'b0, 8'h00);
        repeat (bubbles) begin
            @(posedge clk); #1;
        end
        set_in(sel, 1'b1, b);
        wait_cyc = 0;
        while (get_ready(sel) == 1'b0 && wait_cyc < 40) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        if (get_ready(sel) == 1'b0) chk("accept_timeout", 32'(get_ready(sel)), 32'd1);
        @(posedge clk); #1;
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int sel, input byte_q_t fr, input int bubbles);
        foreach (fr[i]) send_byte(sel, fr[i], bubbles);
    endtask

    task automatic chk_wr(input string tag, input int sel, input int idx, input logic [31:0] exp);
        logic [31:0] act;
        act = 32'hDEAD_BEEF;
        if (sel == 0 && wr0.size() > idx) act = wr0[idx];
        if (sel == 1 && wr1.size() > idx) act = wr1[idx];
        chk(tag, act, exp);
    endtask

    byte_q_t f_nom  = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    byte_q_t f_bad  = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    byte_q_t f_emp  = '{8'h00, 8'h00};
    byte_q_t f_tail = '{8'h34, 8'hAB, 8'hCD, 8'h42};
    byte_q_t f_wrap = '{8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h02};

    initial begin
        Reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;

        chk("rst_state",  32'(state0),        32'd0);
        chk("rst_ready",  32'(bus0.In_Ready), 32'd0);
        chk("rst_wr",     32'(bus0.IM_Wr),    32'd0);
        chk("rst_addr",   32'(bus0.IM_Addr),  32'd0);
        chk("rst_data",   32'(bus0.IM_Data),  32'd0);
        chk("rst_hold",   32'(hold0),         32'd1);
        chk("rst_done",   32'(done0),         32'd0);
        chk("rst_error",  32'(err0),          32'd0);
        chk("rst_addr_w", 32'(bus1.IM_Addr),  32'h7F);

        // Nominal frame
        wr0.delete();
        pulse_start(0);
        chk("start_state", 32'(state0), 32'd1);
        send_frame(0, f_nom, 0);
        chk("nom_state", 32'(state0), 32'd6);
        chk("nom_done",  32'(done0),  32'd1);
        chk("nom_hold",  32'(hold0),  32'd0);
        chk("nom_error", 32'(err0),   32'd0);
        chk("nom_cnt",   32'(wr0.size()), 32'd2);
        chk_wr("nom_w0", 0, 0, 32'h0000_1234);
        chk_wr("nom_w1", 0, 1, 32'h0001_ABCD);
        chk("nom_addr_hold", 32'(bus0.IM_Addr), 32'h01);
        chk("nom_data_hold", 32'(bus0.IM_Data), 32'hABCD);

        // Bad checksum, then recovery with a good frame
        wr0.delete();
        pulse_start(0);
        chk("rst_from_done_state", 32'(state0), 32'd1);
        chk("rst_from_done_hold",  32'(hold0),  32'd1);
        chk("rst_from_done_done",  32'(done0),  32'd0);
        send_frame(0, f_bad, 0);
        chk("bad_state", 32'(state0), 32'd7);
        chk("bad_error", 32'(err0),   32'd1);
        chk("bad_hold",  32'(hold0),  32'd1);
        chk("bad_done",  32'(done0),  32'd0);
        chk("bad_cnt",   32'(wr0.size()), 32'd2);
        chk_wr("bad_w0", 0, 0, 32'h0000_1234);
        chk_wr("bad_w1", 0, 1, 32'h0001_ABCD);
        pulse_start(0);
        chk("rec_error_clr", 32'(err0), 32'd0);
        send_frame(0, f_nom, 0);
        chk("rec_done",  32'(done0), 32'd1);
        chk("rec_error", 32'(err0),  32'd0);

        // Empty frame
        wr0.delete();
        pulse_start(0);
        send_frame(0, f_emp, 0);
        chk("emp_cnt",  32'(wr0.size()), 32'd0);
        chk("emp_done", 32'(done0), 32'd1);
        chk("emp_hold", 32'(hold0), 32'd0);

        // Bubbles between every byte
        wr0.delete();
        pulse_start(0);
        send_frame(0, f_nom, 3);
        chk("bub_done", 32'(done0), 32'd1);
        chk("bub_cnt",  32'(wr0.size()), 32'd2);
        chk_wr("bub_w0", 0, 0, 32'h0000_1234);
        chk_wr("bub_w1", 0, 1, 32'h0001_ABCD);

        // Reset after the HI byte has been accepted
        wr0.delete();
        pulse_start(0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h12, 0);
        chk("mid_in_lo", 32'(state0), 32'd3);
        Reset = 1'b1;
        set_in(0, 1'b1, 8'h34);
        @(posedge clk); #1;
        chk("mid_rst_state", 32'(state0),     32'd0);
        chk("mid_rst_wr",    32'(bus0.IM_Wr), 32'd0);
        chk("mid_rst_hold",  32'(hold0),      32'd1);
        Reset = 1'b0;
        set_in(0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_cnt",  32'(wr0.size()), 32'd0);
        chk("mid_rst_idle", 32'(state0),     32'd0);

        // Start pulse in the middle of a frame is ignored
        pulse_start(0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h12, 0);
        pulse_start(0);
        chk("ign_start_state", 32'(state0), 32'd3);
        send_frame(0, f_tail, 0);
        chk("ign_done", 32'(done0), 32'd1);
        chk("ign_cnt",  32'(wr0.size()), 32'd2);
        chk_wr("ign_w0", 0, 0, 32'h0000_1234);
        chk_wr("ign_w1", 0, 1, 32'h0001_ABCD);

        // Address wrap on the base-7F instance
        wr1.delete();
        pulse_start(1);
        send_frame(1, f_wrap, 0);
        chk("wrap_done", 32'(done1), 32'd1);
        chk("wrap_cnt",  32'(wr1.size()), 32'd2);
        chk_wr("wrap_w0", 1, 0, 32'h007F_1111);
        chk_wr("wrap_w1", 1, 1, 32'h0000_2222);

        chk("ready_in_write0", 32'(rdy_bad0), 32'd0);
        chk("ready_in_write1", 32'(rdy_bad1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
